// File: rtl/feat_fifo_xfer_pkg.sv
// Shared types and default sizes for the feature-memory to FIFO write sequencer.
// Holds the FSM state encoding and the DW/DEPTH/AW defaults.
package feat_fifo_xfer_pkg;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_XFER = 2'd1;
    localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/xfer_skid2.sv
// Two-entry skid buffer holding memory read data ahead of the FIFO push.
// Ports: clk, rst_n, push/push_data in, pop in, valid/head/occ out.
module xfer_skid2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          valid,
    output logic [DW-1:0] head,
    output logic [1:0]    occ
);

    logic [DW-1:0] data0_q, data0_d;
    logic [DW-1:0] data1_q, data1_d;
    logic [1:0]    occ_q, occ_d;

    always_comb begin
        data0_d = data0_q;
        data1_d = data1_q;
        occ_d   = occ_q;
        unique case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) data0_d = push_data;
                else               data1_d = push_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                data0_d = data1_q;
                occ_d   = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; new word lands behind the survivor.
                if (occ_q == 2'd1) begin
                    data0_d = push_data;
                end else begin
                    data0_d = data1_q;
                    data1_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data0_q <= '0;
            data1_q <= '0;
            occ_q   <= 2'd0;
        end else begin
            data0_q <= data0_d;
            data1_q <= data1_d;
            occ_q   <= occ_d;
        end
    end

    assign valid = (occ_q != 2'd0);
    assign head  = data0_q;
    assign occ   = occ_q;

endmodule

// File: rtl/feat_fifo_xfer_ctrl.sv
// Loads a burst of feature words into memory, then streams them into the FIFO.
// Ports: load (ld_en/ld_data), start, memory port, FIFO write port, status.
module feat_fifo_xfer_ctrl
    import feat_fifo_xfer_pkg::*;
#(
    parameter int DW    = feat_fifo_xfer_pkg::DW,
    parameter int DEPTH = feat_fifo_xfer_pkg::DEPTH,
    parameter int AW    = feat_fifo_xfer_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_en,
    input  logic [DW-1:0] ld_data,
    input  logic          start,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          fifo_winc,
    output logic [DW-1:0] fifo_wdata,
    input  logic          fifo_wfull,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count,
    output logic          err
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    state_t      state_q, state_d;
    logic [AW:0] count_q, count_d;
    logic [AW:0] len_q, len_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] pushed_q, pushed_d;
    logic        inflight_q, inflight_d;
    logic        err_q, err_d;

    logic        rd_issue;
    logic        skid_valid;
    logic [1:0]  skid_occ;
    logic [2:0]  pending;

    xfer_skid2 #(.DW(DW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (mem_rdata),
        .pop       (fifo_winc),
        .valid     (skid_valid),
        .head      (fifo_wdata),
        .occ       (skid_occ)
    );

    assign fifo_winc = skid_valid && !fifo_wfull;

    // Words that will sit in the skid after this edge; counting the pop
    // keeps one read issued per cycle while the FIFO accepts.
    assign pending = {1'b0, skid_occ} - {2'b0, fifo_winc}
                   + {2'b0, inflight_q};

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        len_d    = len_q;
        rd_ptr_d = rd_ptr_q;
        pushed_d = pushed_q;
        err_d    = err_q;
        mem_we   = 1'b0;
        rd_issue = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ld_en) begin
                    if (count_q != FULL) begin
                        mem_we  = 1'b1;
                        count_d = count_q + ONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (start) begin
                    len_d    = count_d;
                    rd_ptr_d = '0;
                    pushed_d = '0;
                    state_d  = (count_d == '0) ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                if (ld_en) err_d = 1'b1;
                rd_issue = (rd_ptr_q < len_q) && (pending < 3'd2);
                if (rd_issue) rd_ptr_d = rd_ptr_q + ONE;
                if (fifo_winc) begin
                    pushed_d = pushed_q + ONE;
                    if (pushed_d == len_q) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ld_en) err_d = 1'b1;
                count_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign inflight_d = rd_issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            len_q      <= '0;
            rd_ptr_q   <= '0;
            pushed_q   <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            len_q      <= len_d;
            rd_ptr_q   <= rd_ptr_d;
            pushed_q   <= pushed_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // The load pointer always equals the number of words loaded.
    assign mem_addr  = (state_q == S_XFER) ? rd_ptr_q[AW-1:0]
                                           : count_q[AW-1:0];
    assign mem_wdata = ld_data;
    assign busy      = (state_q == S_XFER);
    assign done      = (state_q == S_DONE);
    assign count     = count_q;
    assign err       = err_q;

endmodule

// File: doc/feat_fifo_xfer_ctrl.md
# feat_fifo_xfer_ctrl

Write-side sequencer between the 16-entry feature memory and the write port of the async FIFO (wfull/winc side). It accepts a burst of feature words into the memory, then on start streams them in order into the FIFO at up to one word per cycle, stalling on full. It owns all memory addressing and FIFO write strobes in the write-clock domain; the read side is unchanged.

## Interface
- DW, 8, data width
- DEPTH, 16, memory entries
- AW, 4, address width, log2(DEPTH)
- clk  in  1  write-domain clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ld_en  in  1  load ld_data into next free entry this cycle
- ld_data  in  DW  word to load
- start  in  1  begin transfer, sampled only in IDLE
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address (load pointer in IDLE, read pointer in XFER)
- mem_wdata  out  DW  equals ld_data
- mem_rdata  in  DW  read data, valid one cycle after mem_addr is sampled
- fifo_winc  out  1  FIFO push
- fifo_wdata  out  DW  push data
- fifo_wfull  in  1  FIFO full, registered in FIFO
- busy  out  1  high in XFER
- done  out  1  one-cycle pulse at transfer end
- count  out  AW+1  words loaded, 0..DEPTH
- err  out  1  sticky: load dropped (memory full or busy); cleared only by reset

## Operation
- States: IDLE, XFER, DONE.
- IDLE: ld_en with count<DEPTH -> mem_we=1, mem_addr=wr_ptr, wr_ptr++, count++. ld_en with count==DEPTH -> dropped, err=1.
- IDLE + start: latch len = count (+1 if ld_en accepted same cycle; that word is included), rd_ptr=0, go XFER. len==0 -> go DONE directly, no push.
- XFER: issue read (rd_ptr++) when rd_ptr<len and skid occupancy + in-flight read < 2. Returned mem_rdata enters 2-entry skid buffer next edge.
- fifo_winc = skid not empty && !fifo_wfull (combinational on fifo_wfull); fifo_wdata = skid head. Pop on winc.
- pushed counter reaches len -> DONE. ld_en in XFER dropped, err=1; start ignored.
- DONE: done=1 for one cycle; wr_ptr, count cleared to 0 (buffer consumed); -> IDLE.
- Order preserved: FIFO receives entries 0..len-1 exactly once, none skipped or duplicated under any wfull pattern.

## Timing
- Reset (async, immediate): state IDLE, all pointers/counters 0; mem_we, fifo_winc, busy, done, err = 0; count=0; mem_addr=0; fifo_wdata=0.
- start sampled at edge E0: read of entry 0 sampled by memory at E1, captured in skid at E2, fifo_winc high in cycle after E2, push sampled at E3.
- wfull low throughout: one push per cycle; word k pushed at E(3+k); done high in the cycle after last push; N words -> done at cycle N+3 after E0.
- wfull high: winc low same cycle; skid absorbs the in-flight read; no data lost; resumes cycle wfull drops.
- rst_n asserted mid-XFER: winc drops immediately; loaded contents discarded (count=0); partial FIFO contents are FIFO's concern.

## Structure
- Package feat_fifo_xfer_pkg: state enum (IDLE, XFER, DONE), DW/DEPTH/AW defaults.
- One sub-module: xfer_skid2 (2-entry valid/data skid, push/pop, occupancy out).
- Memory itself stays outside; this block only drives its ports.

## Test plan
- Load 4,14,24,42,141,243,41,134,204,124,104,24,34,74,84,95, start, wfull=0 -> 16 pushes in that order on 16 consecutive cycles, first at E3, done once, count returns 0.
- Same load, wfull high cycles 5-9 after start -> winc never high while wfull high, all 16 words in order, no duplicates.
- Load 3 words, start with ld_en=1 (data 77) same cycle -> 4 pushes, last is 77.
- start with count=0 -> done pulse next cycle, no winc.
- 17th ld_en in IDLE and ld_en during XFER -> dropped, err=1 and held, transfer unaffected.
- rst_n low after 5 pushes -> winc, busy low immediately; after release count=0, state IDLE, new load/transfer works.
